// File: rtl/writeback_csr_seq.sv
// writeback_csr_seq -- writeback stage with a multi-cycle CSR write sequencer.
// One instruction may carry up to three CSR writes; the single CSR port is
// time-multiplexed over consecutive cycles (IDLE -> CSR2 -> CSR3). The GPR
// write and the first CSR write go out in the first cycle. DONE parks a
// finished instruction while the pipeline is stalled, so nothing is written
// twice.
// Optional feature: define WB_COMMIT_TRACE_EN to add the registered retire
// trace (commit_*); when undefined the trace ports are tied to zero.

typedef logic [63:0] wb_word_t;

// MEM/WB pipeline register contents.
typedef struct packed {
    logic        valid;
    logic        isWriteBack;
    logic [4:0]  wd;
    logic        isJump;
    logic        isMemRead;
    wb_word_t    pcPlus4;
    wb_word_t    memOut;
    wb_word_t    aluOut;
    logic        isCSRWrite;
    logic [11:0] CSR_addr;
    wb_word_t    CSR_write_value;
    logic        isCSRWrite2;
    logic [11:0] CSR_addr2;
    wb_word_t    CSR_write_value2;
    logic        isCSRWrite3;
    logic [11:0] CSR_addr3;
    wb_word_t    CSR_write_value3;
    wb_word_t    instrAddr;
    logic [31:0] instr;
    logic        skip;
} REG_MEM_WB;

// Bypass information handed back to decode/execute.
typedef struct packed {
    logic       valid;
    logic       isWb;
    logic [4:0] wd;
    wb_word_t   wdData;
} FORWARD_SOURCE;

module writeback_csr_seq #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned NUM_CSR_SLOTS = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  REG_MEM_WB       moduleIn,
    input  logic            ok_to_proceed_overall,
    output logic            ok_to_proceed,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            csr_we,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    output FORWARD_SOURCE   forwardSource,
    output logic            instret_inc,
    output logic            commit_valid,
    output logic [63:0]     commit_pc,
    output logic [31:0]     commit_instr,
    output logic            commit_skip
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CSR2 = 2'd1,
        ST_CSR3 = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Slots beyond the configured count are never sequenced.
    localparam bit SLOT2_OK = (NUM_CSR_SLOTS >= 2);
    localparam bit SLOT3_OK = (NUM_CSR_SLOTS >= 3);

    state_e   state_q, state_d;
    logic     slot2_req;
    logic     slot3_req;
    logic     live;
    wb_word_t wb_sel;

    // Slot 3 only exists behind slot 2: CSR2 is the only state that looks at it.
    assign slot2_req = SLOT2_OK & moduleIn.isCSRWrite2;
    assign slot3_req = SLOT3_OK & moduleIn.isCSRWrite3;
    assign live      = moduleIn.valid & (state_q != ST_DONE);

    // Writeback data select: link address, load data or ALU result.
    assign wb_sel = moduleIn.isJump    ? moduleIn.pcPlus4 :
                    moduleIn.isMemRead ? moduleIn.memOut  :
                                         moduleIn.aluOut;

    // State register; reset abandons any CSR slots still pending.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and every write-port output, decoded from state and moduleIn.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case statement can leave one unassigned (no latch).
        state_d   = state_q;
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        csr_we    = 1'b0;
        csr_addr  = '0;
        csr_wdata = '0;

        if (!moduleIn.valid) begin
            // A bubble issues nothing and leaves the sequencer idle.
            state_d = ST_IDLE;
        end else begin
            rf_wa = moduleIn.wd;
            rf_wd = wb_sel[XLEN-1:0];
            case (state_q)
                ST_IDLE: begin
                    rf_we     = moduleIn.isWriteBack & (moduleIn.wd != 5'd0);
                    csr_we    = moduleIn.isCSRWrite;
                    csr_addr  = moduleIn.CSR_addr;
                    csr_wdata = moduleIn.CSR_write_value[XLEN-1:0];
                    if (slot2_req)                  state_d = ST_CSR2;
                    else if (ok_to_proceed_overall) state_d = ST_IDLE;
                    else                            state_d = ST_DONE;
                end
                ST_CSR2: begin
                    csr_we    = 1'b1;
                    csr_addr  = moduleIn.CSR_addr2;
                    csr_wdata = moduleIn.CSR_write_value2[XLEN-1:0];
                    if (slot3_req)                  state_d = ST_CSR3;
                    else if (ok_to_proceed_overall) state_d = ST_IDLE;
                    else                            state_d = ST_DONE;
                end
                ST_CSR3: begin
                    csr_we    = 1'b1;
                    csr_addr  = moduleIn.CSR_addr3;
                    csr_wdata = moduleIn.CSR_write_value3[XLEN-1:0];
                    state_d   = ok_to_proceed_overall ? ST_IDLE : ST_DONE;
                end
                ST_DONE: begin
                    // All writes already issued; wait for the pipeline to move.
                    state_d = ok_to_proceed_overall ? ST_IDLE : ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Stage completion: true on the cycle that issues the last pending write.
    always_comb begin
        ok_to_proceed = ~moduleIn.valid
                      | (state_q == ST_DONE)
                      | ((state_q == ST_IDLE) & ~slot2_req)
                      | ((state_q == ST_CSR2) & ~slot3_req)
                      | (state_q == ST_CSR3);
    end

    assign instret_inc = ok_to_proceed & live;

    // Bypass: the destination is visible until the instruction has finished.
    always_comb begin
        forwardSource        = '0;
        forwardSource.valid  = live & (moduleIn.wd != 5'd0);
        forwardSource.isWb   = moduleIn.isWriteBack;
        forwardSource.wd     = moduleIn.wd;
        forwardSource.wdData = 64'(rf_wd);
    end

`ifdef WB_COMMIT_TRACE_EN
    logic        commit_valid_q;
    logic [63:0] commit_pc_q;
    logic [31:0] commit_instr_q;
    logic        commit_skip_q;

    // Retire trace: captured on the retire pulse, presented one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_instr_q <= '0;
            commit_skip_q  <= 1'b0;
        end else begin
            commit_valid_q <= instret_inc;
            if (instret_inc) begin
                commit_pc_q    <= moduleIn.instrAddr;
                commit_instr_q <= moduleIn.instr;
                commit_skip_q  <= moduleIn.skip;
            end
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;
    assign commit_instr = commit_instr_q;
    assign commit_skip  = commit_skip_q;
`else
    // Trace fields are only consumed by the optional retire trace.
    logic unused_trace_fields;
    assign unused_trace_fields = ^{moduleIn.instrAddr, moduleIn.instr, moduleIn.skip};

    assign commit_valid = 1'b0;
    assign commit_pc    = '0;
    assign commit_instr = '0;
    assign commit_skip  = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_csr_seq.sv
// Bench for writeback_csr_seq: directed scenarios followed by a randomized
// instruction stream checked against a per-instruction step model.
module tb_writeback_csr_seq;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    REG_MEM_WB     min;
    logic          ovr;
    logic          ok_to_proceed, rf_we, csr_we, instret_inc;
    logic          commit_valid, commit_skip;
    logic [4:0]    rf_wa;
    logic [63:0]   rf_wd, csr_wdata, commit_pc;
    logic [11:0]   csr_addr;
    logic [31:0]   commit_instr;
    FORWARD_SOURCE fwd;

    int errors = 0;
    int checks = 0;

    writeback_csr_seq #(.XLEN(64), .NUM_CSR_SLOTS(3)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .moduleIn              (min),
        .ok_to_proceed_overall (ovr),
        .ok_to_proceed         (ok_to_proceed),
        .rf_we                 (rf_we),
        .rf_wa                 (rf_wa),
        .rf_wd                 (rf_wd),
        .csr_we                (csr_we),
        .csr_addr              (csr_addr),
        .csr_wdata             (csr_wdata),
        .forwardSource         (fwd),
        .instret_inc           (instret_inc),
        .commit_valid          (commit_valid),
        .commit_pc             (commit_pc),
        .commit_instr          (commit_instr),
        .commit_skip           (commit_skip)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic REG_MEM_WB bubble();
        REG_MEM_WB r;
        r = '0;
        return r;
    endfunction

    function automatic REG_MEM_WB rand_instr();
        REG_MEM_WB r;
        r = '0;
        r.valid            = ($urandom_range(0, 6) != 0);
        r.isWriteBack      = 1'($urandom_range(0, 1));
        r.wd               = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r.isJump           = ($urandom_range(0, 3) == 0);
        r.isMemRead        = ($urandom_range(0, 2) == 0);
        r.pcPlus4          = {$urandom, $urandom};
        r.memOut           = {$urandom, $urandom};
        r.aluOut           = {$urandom, $urandom};
        r.isCSRWrite       = 1'($urandom_range(0, 1));
        r.CSR_addr         = 12'($urandom);
        r.CSR_write_value  = {$urandom, $urandom};
        r.isCSRWrite2      = 1'($urandom_range(0, 1));
        r.CSR_addr2        = 12'($urandom);
        r.CSR_write_value2 = {$urandom, $urandom};
        r.isCSRWrite3      = 1'($urandom_range(0, 1));
        r.CSR_addr3        = 12'($urandom);
        r.CSR_write_value3 = {$urandom, $urandom};
        r.instrAddr        = {$urandom, $urandom};
        r.instr            = $urandom;
        r.skip             = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Start a cycle: new inputs just after the falling edge, outputs settle 1ns later.
    task automatic drive(input REG_MEM_WB r, input logic o);
        @(negedge clk);
        min = r;
        ovr = o;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        min = bubble();
        ovr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset rf_we got=%b want=0", rf_we); end
        checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL reset csr_we got=%b want=0", csr_we); end
        checks++; if (instret_inc !== 1'b0) begin errors++; $display("FAIL reset instret got=%b want=0", instret_inc); end
        checks++; if (ok_to_proceed !== 1'b1) begin errors++; $display("FAIL reset ok got=%b want=1", ok_to_proceed); end
        checks++; if (fwd.valid !== 1'b0) begin errors++; $display("FAIL reset fwd_valid got=%b want=0", fwd.valid); end
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset commit_valid got=%b want=0", commit_valid); end
        checks++; if (commit_pc !== 64'd0) begin errors++; $display("FAIL reset commit_pc got=%h want=0", commit_pc); end
        checks++; if (commit_instr !== 32'd0) begin errors++; $display("FAIL reset commit_instr got=%h want=0", commit_instr); end
        checks++; if (commit_skip !== 1'b0) begin errors++; $display("FAIL reset commit_skip got=%b want=0", commit_skip); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        REG_MEM_WB r;
        r = bubble();
        r.valid = 1'b1; r.isWriteBack = 1'b1; r.wd = 5'd5;
        r.aluOut = 64'h1234; r.memOut = 64'hdead; r.pcPlus4 = 64'h8000_0004;
        r.instrAddr = 64'h8000_0000; r.instr = 32'h0010_02b3;
        drive(r, 1'b1);
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL add rf_we got=%b want=1", rf_we); end
        checks++; if (rf_wa !== 5'd5) begin errors++; $display("FAIL add rf_wa got=%0d want=5", rf_wa); end
        checks++; if (rf_wd !== 64'h1234) begin errors++; $display("FAIL add rf_wd got=%h want=1234", rf_wd); end
        checks++; if (ok_to_proceed !== 1'b1) begin errors++; $display("FAIL add ok got=%b want=1", ok_to_proceed); end
        checks++; if (instret_inc !== 1'b1) begin errors++; $display("FAIL add instret got=%b want=1", instret_inc); end
        checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL add csr_we got=%b want=0", csr_we); end
        checks++; if (fwd.valid !== 1'b1 || fwd.wdData !== 64'h1234) begin
            errors++; $display("FAIL add fwd got=%b/%h want=1/1234", fwd.valid, fwd.wdData); end
        drive(bubble(), 1'b1);
        checks++; if (rf_we !== 1'b0 || instret_inc !== 1'b0) begin
            errors++; $display("FAIL add_after we/instret got=%b/%b want=0/0", rf_we, instret_inc); end
`ifdef WB_COMMIT_TRACE_EN
        checks++; if (commit_valid !== 1'b1 || commit_pc !== 64'h8000_0000 || commit_instr !== 32'h0010_02b3) begin
            errors++; $display("FAIL add_commit got=%b/%h/%h want=1/80000000/001002b3", commit_valid, commit_pc, commit_instr); end
`else
        checks++; if (commit_valid !== 1'b0 || commit_pc !== 64'd0) begin
            errors++; $display("FAIL add_commit_off got=%b/%h want=0/0", commit_valid, commit_pc); end
`endif
    endtask

    task automatic test_wd_zero();
        REG_MEM_WB r;
        r = bubble();
        r.valid = 1'b1; r.isWriteBack = 1'b1; r.wd = 5'd0; r.aluOut = {$urandom, $urandom};
        drive(r, 1'b1);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL wd0 rf_we got=%b want=0", rf_we); end
        checks++; if (fwd.valid !== 1'b0) begin errors++; $display("FAIL wd0 fwd_valid got=%b want=0", fwd.valid); end
        checks++; if (ok_to_proceed !== 1'b1) begin errors++; $display("FAIL wd0 ok got=%b want=1", ok_to_proceed); end
    endtask

    task automatic test_exception_entry();
        REG_MEM_WB   r;
        logic [11:0] ea [3];
        logic [63:0] ev [3];
        ea[0] = 12'h300; ea[1] = 12'h341; ea[2] = 12'h342;
        ev[0] = 64'h0000_0000_0000_1800; ev[1] = 64'h8000_0040; ev[2] = 64'd2;
        r = bubble();
        r.valid = 1'b1;
        r.isCSRWrite  = 1'b1; r.CSR_addr  = ea[0]; r.CSR_write_value  = ev[0];
        r.isCSRWrite2 = 1'b1; r.CSR_addr2 = ea[1]; r.CSR_write_value2 = ev[1];
        r.isCSRWrite3 = 1'b1; r.CSR_addr3 = ea[2]; r.CSR_write_value3 = ev[2];
        for (int k = 0; k < 3; k++) begin
            drive(r, 1'b0);
            checks++; if (csr_we !== 1'b1 || csr_addr !== ea[k] || csr_wdata !== ev[k]) begin
                errors++; $display("FAIL exc slot%0d got=%b/%h/%h want=1/%h/%h", k + 1, csr_we, csr_addr, csr_wdata, ea[k], ev[k]); end
            checks++; if (ok_to_proceed !== (k == 2)) begin
                errors++; $display("FAIL exc ok cycle%0d got=%b want=%b", k + 1, ok_to_proceed, (k == 2)); end
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL exc rf_we cycle%0d got=%b want=0", k + 1, rf_we); end
            ovr = (k == 2);
        end
        drive(bubble(), 1'b1);
        checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL exc_after csr_we got=%b want=0", csr_we); end
    endtask

    task automatic test_jal_stall();
        REG_MEM_WB r, r2;
        int nwr;
        nwr = 0;
        r = bubble();
        r.valid = 1'b1; r.isJump = 1'b1; r.isWriteBack = 1'b1; r.wd = 5'd1;
        r.pcPlus4 = 64'h8000_0008; r.aluOut = 64'h8000_0100; r.memOut = {$urandom, $urandom};
        for (int k = 0; k < 4; k++) begin
            drive(r, 1'b0);
            if (rf_we === 1'b1) nwr++;
            if (k == 0) begin
                checks++; if (rf_we !== 1'b1 || rf_wd !== 64'h8000_0008) begin
                    errors++; $display("FAIL jal write got=%b/%h want=1/80000008", rf_we, rf_wd); end
            end
            checks++; if (instret_inc !== (k == 0) || ok_to_proceed !== 1'b1) begin
                errors++; $display("FAIL jal stall%0d instret/ok got=%b/%b want=%b/1", k, instret_inc, ok_to_proceed, (k == 0)); end
        end
        drive(r, 1'b1);
        if (rf_we === 1'b1) nwr++;
        checks++; if (rf_we !== 1'b0 || instret_inc !== 1'b0) begin
            errors++; $display("FAIL jal done got=%b/%b want=0/0", rf_we, instret_inc); end
        checks++; if (nwr != 1) begin errors++; $display("FAIL jal write_count got=%0d want=1", nwr); end
        r2 = bubble();
        r2.valid = 1'b1; r2.isWriteBack = 1'b1; r2.wd = 5'd7; r2.aluOut = 64'h77;
        drive(r2, 1'b1);
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 64'h77) begin
            errors++; $display("FAIL jal next got=%b/%0d/%h want=1/7/77", rf_we, rf_wa, rf_wd); end
    endtask

    task automatic test_reset_mid_seq();
        REG_MEM_WB r, r2;
        r = bubble();
        r.valid = 1'b1;
        r.isCSRWrite  = 1'b1; r.CSR_addr  = 12'h300; r.CSR_write_value  = 64'h11;
        r.isCSRWrite2 = 1'b1; r.CSR_addr2 = 12'h341; r.CSR_write_value2 = 64'h22;
        r.isCSRWrite3 = 1'b1; r.CSR_addr3 = 12'h342; r.CSR_write_value3 = 64'h33;
        drive(r, 1'b0);
        checks++; if (csr_addr !== 12'h300) begin errors++; $display("FAIL rstmid slot1 got=%h want=300", csr_addr); end
        drive(r, 1'b0);
        checks++; if (csr_we !== 1'b1 || csr_addr !== 12'h341) begin
            errors++; $display("FAIL rstmid slot2 got=%b/%h want=1/341", csr_we, csr_addr); end
        #1;
        rst = 1'b1;
        min = bubble();
        @(negedge clk);
        #1;
        checks++; if (csr_we !== 1'b0 || commit_valid !== 1'b0 || ok_to_proceed !== 1'b1) begin
            errors++; $display("FAIL rstmid in_reset got=%b/%b/%b want=0/0/1", csr_we, commit_valid, ok_to_proceed); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(bubble(), 1'b1);
            checks++; if (csr_we !== 1'b0 || commit_valid !== 1'b0) begin
                errors++; $display("FAIL rstmid after%0d csr_we/commit got=%b/%b want=0/0", k, csr_we, commit_valid); end
        end
        r2 = bubble();
        r2.valid = 1'b1; r2.isWriteBack = 1'b1; r2.wd = 5'd9; r2.aluOut = 64'h99;
        r2.isCSRWrite = 1'b1; r2.CSR_addr = 12'h305; r2.CSR_write_value = 64'h8000_0000;
        drive(r2, 1'b1);
        checks++; if (rf_we !== 1'b1 || csr_we !== 1'b1 || csr_addr !== 12'h305 || ok_to_proceed !== 1'b1) begin
            errors++; $display("FAIL rstmid idle got=%b/%b/%h/%b want=1/1/305/1", rf_we, csr_we, csr_addr, ok_to_proceed); end
    endtask

    task automatic test_commit_trace();
        REG_MEM_WB   r;
        logic [63:0] ld;
        ld = {$urandom, $urandom};
        r = bubble();
        r.valid = 1'b1; r.isMemRead = 1'b1; r.isWriteBack = 1'b1; r.wd = 5'd10;
        r.memOut = ld; r.aluOut = 64'h8000_0200; r.instrAddr = 64'h8000_0100; r.instr = 32'h0005_3503;
        drive(r, 1'b1);
        checks++; if (rf_wd !== ld || instret_inc !== 1'b1) begin
            errors++; $display("FAIL load rf_wd/instret got=%h/%b want=%h/1", rf_wd, instret_inc, ld); end
        drive(bubble(), 1'b1);
`ifdef WB_COMMIT_TRACE_EN
        checks++; if (commit_valid !== 1'b1 || commit_pc !== 64'h8000_0100 || commit_instr !== 32'h0005_3503 || commit_skip !== 1'b0) begin
            errors++; $display("FAIL trace got=%b/%h/%h/%b want=1/80000100/00053503/0", commit_valid, commit_pc, commit_instr, commit_skip); end
`else
        checks++; if (commit_valid !== 1'b0 || commit_pc !== 64'd0 || commit_instr !== 32'd0) begin
            errors++; $display("FAIL trace_off got=%b/%h/%h want=0/0/0", commit_valid, commit_pc, commit_instr); end
`endif
        drive(bubble(), 1'b1);
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL trace_pulse got=%b want=0", commit_valid); end
    endtask

    // Model: an instruction needs 1 + (slot2 ? 1 + slot3 : 0) issue cycles; cycle k
    // carries the GPR write (k==0) and CSR slot k+1; after that it only waits.
    task automatic test_random();
        REG_MEM_WB   cur, prev;
        int          step, nsteps;
        logic        adv, allow, live, e_rf, e_csr, e_ok, e_ret, e_fwd, prev_ret;
        logic [11:0] e_ca;
        logic [63:0] e_cv, e_wd;
        adv = 1'b1; prev_ret = 1'b0; prev = bubble(); cur = bubble(); step = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (adv) begin cur = rand_instr(); step = 0; end
            allow = ($urandom_range(0, 3) != 0);
            drive(cur, 1'b0);
            nsteps = 1 + (cur.isCSRWrite2 ? (cur.isCSRWrite3 ? 2 : 1) : 0);
            live   = cur.valid && (step < nsteps);
            e_wd   = cur.isJump ? cur.pcPlus4 : (cur.isMemRead ? cur.memOut : cur.aluOut);
            e_rf   = live && step == 0 && cur.isWriteBack && cur.wd != 5'd0;
            e_csr  = live && (step == 0 ? cur.isCSRWrite : 1'b1);
            e_ca   = (step == 0) ? cur.CSR_addr : (step == 1) ? cur.CSR_addr2 : cur.CSR_addr3;
            e_cv   = (step == 0) ? cur.CSR_write_value : (step == 1) ? cur.CSR_write_value2 : cur.CSR_write_value3;
            e_ok   = !cur.valid || step >= nsteps - 1;
            e_ret  = cur.valid && step == nsteps - 1;
            e_fwd  = live && cur.wd != 5'd0;
            checks++; if (rf_we !== e_rf) begin errors++; $display("FAIL rnd rf_we cyc=%0d got=%b want=%b", cyc, rf_we, e_rf); end
            if (e_rf) begin
                checks++; if (rf_wa !== cur.wd || rf_wd !== e_wd) begin
                    errors++; $display("FAIL rnd rf_data cyc=%0d got=%0d/%h want=%0d/%h", cyc, rf_wa, rf_wd, cur.wd, e_wd); end
            end
            checks++; if (csr_we !== e_csr) begin errors++; $display("FAIL rnd csr_we cyc=%0d got=%b want=%b", cyc, csr_we, e_csr); end
            if (e_csr) begin
                checks++; if (csr_addr !== e_ca || csr_wdata !== e_cv) begin
                    errors++; $display("FAIL rnd csr_data cyc=%0d got=%h/%h want=%h/%h", cyc, csr_addr, csr_wdata, e_ca, e_cv); end
            end
            checks++; if (ok_to_proceed !== e_ok) begin errors++; $display("FAIL rnd ok cyc=%0d got=%b want=%b", cyc, ok_to_proceed, e_ok); end
            checks++; if (instret_inc !== e_ret) begin errors++; $display("FAIL rnd instret cyc=%0d got=%b want=%b", cyc, instret_inc, e_ret); end
            checks++; if (fwd.valid !== e_fwd) begin errors++; $display("FAIL rnd fwd_valid cyc=%0d got=%b want=%b", cyc, fwd.valid, e_fwd); end
            if (e_fwd) begin
                checks++; if (fwd.wd !== cur.wd || fwd.wdData !== e_wd || fwd.isWb !== cur.isWriteBack) begin
                    errors++; $display("FAIL rnd fwd_data cyc=%0d got=%0d/%h/%b want=%0d/%h/%b", cyc, fwd.wd, fwd.wdData, fwd.isWb, cur.wd, e_wd, cur.isWriteBack); end
            end
`ifdef WB_COMMIT_TRACE_EN
            checks++; if (commit_valid !== prev_ret) begin errors++; $display("FAIL rnd commit_valid cyc=%0d got=%b want=%b", cyc, commit_valid, prev_ret); end
            if (prev_ret) begin
                checks++; if (commit_pc !== prev.instrAddr || commit_instr !== prev.instr || commit_skip !== prev.skip) begin
                    errors++; $display("FAIL rnd commit_data cyc=%0d got=%h/%h/%b want=%h/%h/%b", cyc, commit_pc, commit_instr, commit_skip, prev.instrAddr, prev.instr, prev.skip); end
            end
`else
            checks++; if (commit_valid !== 1'b0 || commit_pc !== 64'd0) begin
                errors++; $display("FAIL rnd commit_off cyc=%0d got=%b/%h want=0/0", cyc, commit_valid, commit_pc); end
`endif
            ovr      = e_ok && allow;
            adv      = ovr;
            prev_ret = e_ret;
            if (e_ret) prev = cur;
            if (!adv) step++;
        end
        drive(bubble(), 1'b1);
    endtask

    initial begin
        min = bubble();
        ovr = 1'b0;
        test_reset();
        test_add();
        test_wd_zero();
        test_exception_entry();
        test_jal_stall();
        test_reset_mid_seq();
        test_commit_trace();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_csr_seq.md
WRITEBACK_CSR_SEQ -- requirements
Module: writeback_csr_seq

Interface
REQ-001 Parameter XLEN, default 64, GPR/CSR data width.
REQ-002 Parameter NUM_CSR_SLOTS, default 3, max CSR writes carried per instruction.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 moduleIn  in  REG_MEM_WB  MEM/WB stage register; held stable while ok_to_proceed_overall low.
REQ-006 ok_to_proceed_overall  in  1  global advance; high moves the pipeline one step.
REQ-007 ok_to_proceed  out  1  high when this stage has finished all writes for the current instruction.
REQ-008 rf_we / rf_wa / rf_wd  out  1/5/XLEN  GPR write port.
REQ-009 csr_we / csr_addr / csr_wdata  out  1/12/XLEN  single CSR write port.
REQ-010 forwardSource  out  FORWARD_SOURCE  bypass to decode/execute.
REQ-011 instret_inc  out  1  one-cycle pulse per retired instruction.
REQ-012 commit_valid / commit_pc / commit_instr / commit_skip  out  1/64/32/1  registered retire trace.

Function
REQ-013 States: IDLE, CSR2, CSR3, DONE; state register only, all write-port outputs combinational from state and moduleIn.
REQ-014 Instruction is "live" when moduleIn.valid and state != DONE.
REQ-015 IDLE, live: rf_we = isWriteBack & (wd != 0); rf_wd = isJump ? pcPlus4 : isMemRead ? memOut : aluOut; csr_we = isCSRWrite with CSR_addr/CSR_write_value.
REQ-016 IDLE next: isCSRWrite2 -> CSR2; else if ok_to_proceed_overall -> IDLE; else -> DONE.
REQ-017 CSR2: csr_we=1 with CSR_addr2/CSR_write_value2, rf_we=0; next: isCSRWrite3 -> CSR3, else (ok_to_proceed_overall ? IDLE : DONE).
REQ-018 CSR3: csr_we=1 with CSR_addr3/CSR_write_value3; next: ok_to_proceed_overall ? IDLE : DONE.
REQ-019 DONE: no writes issued; stays until ok_to_proceed_overall, then IDLE.
REQ-020 ok_to_proceed = ~moduleIn.valid | state==DONE | (state==IDLE & ~isCSRWrite2) | (state==CSR2 & ~isCSRWrite3) | state==CSR3.
REQ-021 Latency: 1 cycle with no extra CSR writes, 2 with isCSRWrite2 only, 3 with all three; each GPR/CSR write issued exactly once per instruction regardless of stall length.
REQ-022 Writes within one instruction occur in order slot1, slot2, slot3; same address repeated -> last value wins.
REQ-023 isCSRWrite3 without isCSRWrite2 is ignored (slot 3 not written).
REQ-024 forwardSource.valid = moduleIn.valid & wd != 0 & state != DONE; isWb = isWriteBack; wd, wdData = rf_wd.
REQ-025 instret_inc pulses in the cycle ok_to_proceed & moduleIn.valid & state != DONE.
REQ-026 Invalid moduleIn: no writes, state stays IDLE.

Reset
REQ-027 On rst: state IDLE; instret_inc, commit_valid, commit_skip 0; commit_pc, commit_instr 0; combinational ports inactive while moduleIn.valid low.
REQ-028 rst asserted mid-sequence (CSR2/CSR3) abandons remaining slots; after release none are issued for that instruction.

Configuration
REQ-029 Macro WB_COMMIT_TRACE_EN: defined -> commit_* registered, commit_valid pulses one cycle after instret_inc carrying that instruction's instrAddr, instr, skip.
REQ-030 Undefined -> commit_* tied to 0, no trace registers; all other behaviour identical.

Verification
REQ-031 ADD wd=5 aluOut=0x1234, overall=1 -> rf_we=1 wa=5 wd=0x1234 same cycle, ok_to_proceed=1, instret_inc=1.
REQ-032 wd=0 isWriteBack=1 -> rf_we=0, forwardSource.valid=0.
REQ-033 Exception entry (three CSR slots 0x300/0x341/0x342) -> csr_we on 3 consecutive cycles in order, ok_to_proceed low cycles 1-2, high cycle 3.
REQ-034 JAL pcPlus4=0x80000008, overall=0 for 4 cycles -> single rf write 0x80000008, state DONE, no repeat, IDLE after overall=1.
REQ-035 rst asserted in CSR2 -> no 0x342 write, state IDLE, commit_valid=0.
REQ-036 With WB_COMMIT_TRACE_EN, load at pc 0x80000100 -> commit_valid=1 next cycle, commit_pc=0x80000100.
